reg_writeback_unit: RTL
=======================

Name: reg_writeback_unit

Overview:
- Writer-side front end for the 16-entry register file: it owns the file's write port (RW, BusW, EnW).
- Accepts write-back requests from two pipeline sources, the ALU result path and the memory-load path.
- Buffers requests in a small in-order FIFO and retires at most one register write per cycle.
- Provides a bypass lookup so operand fetch can see values that are still pending, before they land in the file.

Parameters:
- DATA_WIDTH, 32, width of register data
- ADDR_WIDTH, 4, register index width (16 registers)
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- alu_valid  input  1  ALU write-back request
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- alu_ready  output  1  ALU request accepted this cycle if alu_valid
- mem_valid  input  1  load write-back request
- mem_rd  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- mem_ready  output  1  load request accepted this cycle if mem_valid
- drain_en  input  1  register file enable; when 0 no write is issued
- RW  output  ADDR_WIDTH  register file write address
- BusW  output  DATA_WIDTH  register file write data
- EnW  output  1  register file write enable, one-cycle pulse per write
- query_reg  input  ADDR_WIDTH  bypass lookup index
- hit  output  1  a pending write to query_reg exists
- hit_data  output  DATA_WIDTH  youngest pending value for query_reg, 0 if no hit
- busy  output  1  count != 0 or EnW = 1
- count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset = 0 at an edge):
  - count, read pointer and write pointer go to 0.
  - RW = 0, BusW = 0, EnW = 0.
  - FIFO contents are discarded, including mid-operation entries and any EnW that would have asserted.
  - While reset is low, alu_ready = mem_ready = 0 and hit = 0.
- Ready generation (combinational; uses registered count only, so a same-cycle pop frees no space):
  - mem_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH-1) OR (count = DEPTH-1 AND mem_valid = 0).
  - When both sources are valid with one free slot, mem wins and ALU waits.
- Enqueue order: a load is the older instruction, so it is pushed before the ALU entry in the same cycle.
  - Both pushes can occur in one edge; count increases by up to 2.
  - Pushes occur only when valid AND ready.
- Dequeue, at each edge with reset = 1:
  - If drain_en = 1 and count > 0 (count before the edge): head entry goes to RW/BusW, EnW <= 1, and the read pointer advances.
  - Otherwise EnW <= 0, and RW/BusW hold their previous values.
  - An entry pushed at edge E0 can be issued at E1 at the earliest; the register file writes it at E2.
  - Fixed latency of 2 edges from acceptance to file update when not stalled.
- Simultaneous push and pop:
  - Allowed, including at count = DEPTH (pop only, since ready = 0).
  - Next count = count + pushes − pop.
  - Pointers wrap modulo DEPTH.
- Ordering: writes to the same register retire strictly in acceptance order. No coalescing and no dropping.
- Bypass (combinational):
  - Searches the valid FIFO entries plus the output stage (RW/BusW while EnW = 1).
  - Youngest match wins; FIFO entries are younger than the output stage, and younger FIFO slots win.
  - hit_data = 0 when hit = 0.
  - Register index 0 is treated like any other index.
- Overflow and underflow are impossible by construction. An assertion must fire if count > DEPTH.

Test Plan:
- Reset then single ALU write (alu_valid for 1 cycle, rd = 1, data = 16) -> count = 1 after E0; at E1 RW = 1, BusW = 16, EnW = 1 for exactly one cycle; count = 0; busy low after E2.
- Same-cycle dual request (mem rd = 2, data = 32; alu rd = 2, data = 64) with drain_en = 1 -> writes issue on consecutive cycles, 32 then 64; query_reg = 2 returns 64 until the second EnW cycle ends.
- Fill with drain_en = 0: push four ALU writes (rd = 3..6, data 100..103) -> count = 4, alu_ready = mem_ready = 0, EnW stays 0; raise drain_en -> four EnW pulses in order 100..103.
- count = 3, both sources valid -> mem accepted, alu_ready = 0; the following cycle with drain active -> ALU accepted; retire order is mem then ALU.
- Wrap-around: stream 10 back-to-back ALU writes with drain_en = 1 -> count never exceeds 2, all 10 retire in order, pointers wrap with no data corruption.
- Reset asserted with count = 3 and EnW = 1 -> after the edge, EnW = 0, count = 0, hit = 0; none of the discarded entries is ever written.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: writer-side front end for the register file.
// Collects write-back requests from the load path and the ALU path into an
// in-order FIFO and retires at most one register write per cycle through
// the file's write port. Pending values are exposed through a bypass lookup.
//
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   alu_valid/rd/data/ready ALU write-back request handshake
//   mem_valid/rd/data/ready load write-back request handshake
//   drain_en                register file enable; 0 stalls retirement
//   RW, BusW, EnW           register file write port (registered)
//   query_reg, hit, hit_data bypass lookup (combinational)
//   busy, count             occupancy status
module reg_writeback_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  output logic                        alu_ready,
  input  logic                        mem_valid,
  input  logic [ADDR_WIDTH-1:0]       mem_rd,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        mem_ready,
  input  logic                        drain_en,
  output logic [ADDR_WIDTH-1:0]       RW,
  output logic [DATA_WIDTH-1:0]       BusW,
  output logic                        EnW,
  input  logic [ADDR_WIDTH-1:0]       query_reg,
  output logic                        hit,
  output logic [DATA_WIDTH-1:0]       hit_data,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // FIFO storage (contents need no reset; validity comes from count_q)
  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic [ADDR_WIDTH-1:0] rw_q;
  logic [DATA_WIDTH-1:0] busw_q;
  logic                  enw_q;

  logic                  mem_push;
  logic                  alu_push;
  logic                  pop;
  logic [PW-1:0]         alu_idx;

  // Ready uses registered occupancy only; load wins the last free slot
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (reset) begin
      mem_ready = (count_q < CW'(DEPTH));
      alu_ready = (count_q < CW'(DEPTH - 1)) ||
                  ((count_q == CW'(DEPTH - 1)) && !mem_valid);
    end
  end

  // Load is the older instruction, so it takes the lower slot
  always_comb begin
    mem_push = mem_valid && mem_ready;
    alu_push = alu_valid && alu_ready;
    pop      = drain_en && (count_q != '0);
    alu_idx  = wr_ptr_q + PW'(mem_push);
    wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Control state and register file write port
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rw_q     <= '0;
      busw_q   <= '0;
      enw_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      enw_q    <= pop;
      if (pop) begin
        rw_q   <= rd_q[rd_ptr_q];
        busw_q <= data_q[rd_ptr_q];
      end
    end
  end

  // FIFO slot writes; pushes never target the head while it is still valid
  always_ff @(posedge clock) begin
    if (mem_push) begin
      rd_q[wr_ptr_q]   <= mem_rd;
      data_q[wr_ptr_q] <= mem_data;
    end
    if (alu_push) begin
      rd_q[alu_idx]   <= alu_rd;
      data_q[alu_idx] <= alu_data;
    end
  end

  // Bypass: output stage is oldest, then FIFO head to tail; last match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (reset) begin
      if (enw_q && (rw_q == query_reg)) begin
        hit      = 1'b1;
        hit_data = busw_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) && (rd_q[rd_ptr_q + PW'(i)] == query_reg)) begin
          hit      = 1'b1;
          hit_data = data_q[rd_ptr_q + PW'(i)];
        end
      end
    end
  end

  assign RW    = rw_q;
  assign BusW  = busw_q;
  assign EnW   = enw_q;
  assign count = count_q;
  assign busy  = (count_q != '0) || enw_q;

  count_bound_a: assert property (@(posedge clock) disable iff (!reset)
                                  count_q <= CW'(DEPTH));

endmodule
